// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer_if
//  Purpose  : Request/result bundle for shift_sequencer. The requester drives
//             start/op/shamt/data_in; the sequencer returns busy/done, the
//             registered result and the latched, zero-extended shift amount.
//  Signals  : start     - operation request, sampled only while idle
//             op        - 00 SLL, 01 SRL, 10 SRA, 11 ROTR
//             shamt     - shift amount 0..31
//             data_in   - 32-bit operand
//             busy      - high while an operation is in flight
//             done      - one-cycle completion pulse
//             data_out  - result, held until the next completion
//             ext_shamt - {27'b0, shamt} captured on accept
//  Modports : master (requester), slave (sequencer)
//  Revision : 1.0 - initial release
// ============================================================================
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [31:0] ext_shamt;

  modport master (
    output start, op, shamt, data_in,
    input  busy, done, data_out, ext_shamt
  );

  modport slave (
    input  start, op, shamt, data_in,
    output busy, done, data_out, ext_shamt
  );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer
//  Purpose  : Multi-cycle 32-bit shifter (SLL/SRL/SRA/ROTR). An accepted
//             request is shifted one bit per clock through IDLE -> SHIFT ->
//             DONE; done pulses for one cycle with the result on data_out.
//  Ports    : clk - rising-edge clock
//             rst - asynchronous active-high reset, clears all state
//             bus - shift_sequencer_if.slave (start/op/shamt/data_in in,
//                   busy/done/data_out/ext_shamt out)
//  Options  : SHIFT_SEQ_SINGLE_CYCLE_EN - when defined, SHIFT performs the
//             whole shamt-bit shift in a single edge using a barrel shifter.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer (
  input  wire logic        clk,
  input  wire logic        rst,
  shift_sequencer_if.slave bus
);

  localparam logic [1:0] c_OP_SLL  = 2'b00;
  localparam logic [1:0] c_OP_SRL  = 2'b01;
  localparam logic [1:0] c_OP_SRA  = 2'b10;
  localparam logic [1:0] c_OP_ROTR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_data_out;
  logic [31:0] r_ext_shamt;

  // Accumulator value after this SHIFT edge, and whether this edge finishes.
  logic [31:0] w_acc_next;
  logic        w_last;

`ifdef SHIFT_SEQ_SINGLE_CYCLE_EN
  // Whole shift in one edge. SHIFT is only entered with a non-zero count,
  // so the rotate's left-shift amount (32 - cnt) stays within 1..31.
  always_comb begin
    w_acc_next = r_acc;
    w_last     = 1'b1;
    case (r_op)
      c_OP_SLL:  w_acc_next = r_acc << r_cnt;
      c_OP_SRL:  w_acc_next = r_acc >> r_cnt;
      c_OP_SRA:  w_acc_next = $unsigned($signed(r_acc) >>> r_cnt);
      c_OP_ROTR: w_acc_next = (r_acc >> r_cnt) | (r_acc << (6'd32 - {1'b0, r_cnt}));
      default:   w_acc_next = r_acc;
    endcase
  end
`else
  // One bit per edge; finishes on the edge where the count is 1.
  always_comb begin
    w_acc_next = r_acc;
    w_last     = (r_cnt == 5'd1);
    case (r_op)
      c_OP_SLL:  w_acc_next = {r_acc[30:0], 1'b0};
      c_OP_SRL:  w_acc_next = {1'b0, r_acc[31:1]};
      c_OP_SRA:  w_acc_next = {r_acc[31], r_acc[31:1]};
      c_OP_ROTR: w_acc_next = {r_acc[0], r_acc[31:1]};
      default:   w_acc_next = r_acc;
    endcase
  end
`endif

  // busy/done are registered alongside the state so they change exactly on
  // state transitions; data_out is written only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= 32'd0;
      r_cnt       <= 5'd0;
      r_op        <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_data_out  <= 32'd0;
      r_ext_shamt <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_acc       <= bus.data_in;
            r_cnt       <= bus.shamt;
            r_op        <= bus.op;
            r_ext_shamt <= {27'd0, bus.shamt};
            r_busy      <= 1'b1;
            if (bus.shamt != 5'd0) begin
              r_state <= ST_SHIFT;
            end else begin
              // Zero shift: result is the operand itself, complete next cycle.
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_data_out <= bus.data_in;
            end
          end
        end

        ST_SHIFT: begin
          r_acc <= w_acc_next;
`ifdef SHIFT_SEQ_SINGLE_CYCLE_EN
          r_cnt <= 5'd0;
`else
          r_cnt <= r_cnt - 5'd1;
`endif
          if (w_last) begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_data_out <= w_acc_next;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.data_out  = r_data_out;
  assign bus.ext_shamt = r_ext_shamt;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_sequencer
//  Purpose  : Self-checking bench for shift_sequencer. The stimulus process
//             issues directed operations and pushes the hand-computed result,
//             ext_shamt and completion cycle into a queue; a monitor pops and
//             compares whenever done is seen.
//  Options  : honours SHIFT_SEQ_SINGLE_CYCLE_EN for expected latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  typedef struct {
    logic [31:0] data;
    logic [31:0] ext;
    int          cyc;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_total;
  int   n_done_seen;
  int   n_pushed;
  exp_t sb_q[$];

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  function automatic int lat(input logic [4:0] s);
`ifdef SHIFT_SEQ_SINGLE_CYCLE_EN
    return (s == 5'd0) ? 1 : 2;
`else
    return int'(s) + 1;
`endif
  endfunction

  // Monitor: every done cycle pops one expectation and compares it.
  initial begin : monitor
    logic prev_done;
    exp_t x;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_done_seen++;
        check("done_not_consecutive", {31'd0, prev_done}, 32'd0);
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          x = sb_q.pop_front();
          check({x.name, "_data_out"}, bus.data_out, x.data);
          check({x.name, "_ext_shamt"}, bus.ext_shamt, x.ext);
          check({x.name, "_latency_cycle"}, cyc, x.cyc);
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic push_exp(input string name, input logic [4:0] s, input logic [31:0] e);
    exp_t x;
    x.data = e;
    x.ext  = {27'd0, s};
    x.cyc  = cyc + lat(s);
    x.name = name;
    sb_q.push_back(x);
    n_pushed++;
  endtask

  // Issue one operation at a negedge, scramble inputs while busy, and wait
  // (bounded) for the block to return idle, checking the busy length.
  task automatic run_op(input string name, input logic [1:0] o, input logic [4:0] s,
                        input logic [31:0] d, input logic [31:0] e);
    int n;
    push_exp(name, s, e);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.shamt   = s;
    bus.data_in = d;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.op      = ~o;
    bus.shamt   = ~s;
    bus.data_in = ~d;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, n, lat(s));
  endtask

  initial begin : stimulus
    n_pass = 0; n_total = 0; n_done_seen = 0; n_pushed = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.shamt = 5'd0; bus.data_in = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_data_out", bus.data_out, 32'd0);
    check("reset_ext_shamt", bus.ext_shamt, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("sll_1_31",     2'b00, 5'd31, 32'h00000001, 32'h80000000);
    run_op("sra_8000_4",   2'b10, 5'd4,  32'h80000000, 32'hF8000000);
    run_op("srl_8000_4",   2'b01, 5'd4,  32'h80000000, 32'h08000000);
    run_op("srl_dead_0",   2'b01, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF);
    run_op("rotr_1234_8",  2'b11, 5'd8,  32'h12345678, 32'h78123456);
    run_op("sll_ffff_1",   2'b00, 5'd1,  32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("sra_7fff_31",  2'b10, 5'd31, 32'h7FFFFFFF, 32'h00000000);
    run_op("sra_ffff0_16", 2'b10, 5'd16, 32'hFFFF0000, 32'hFFFFFFFF);

    // ROTR 1 by 1 with a second start pulsed while busy: one done only.
    push_exp("rotr_1_1", 5'd1, 32'h80000000);
    bus.start = 1'b1; bus.op = 2'b11; bus.shamt = 5'd1; bus.data_in = 32'h00000001;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.shamt = 5'd7; bus.data_in = 32'h0000FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("ignored_start_idle", {31'd0, bus.busy}, 32'd0);

    // Reset mid-shift: outputs clear within the same cycle, op discarded.
    bus.start = 1'b1; bus.op = 2'b00; bus.shamt = 5'd10; bus.data_in = 32'h00000005;
    @(negedge clk);
    bus.start = 1'b0;
`ifndef SHIFT_SEQ_SINGLE_CYCLE_EN
    repeat (3) @(negedge clk);
`endif
    check("midrst_pre_busy", {31'd0, bus.busy}, 32'd1);
    check("midrst_pre_ext_shamt", bus.ext_shamt, 32'd10);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_data_out", bus.data_out, 32'd0);
    check("midrst_ext_shamt", bus.ext_shamt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_sll_3_2", 2'b00, 5'd2, 32'h00000003, 32'h0000000C);

    repeat (40) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    check("done_pulse_count", n_done_seen, n_pushed);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
- REQ-001: The block SHALL have no parameters; data width is fixed at 32 bits and shift amount at 5 bits.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: start  input  1  request; sampled only in IDLE.
- REQ-005: op  input  2  shift type: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- REQ-006: shamt  input  5  shift amount, 0..31.
- REQ-007: data_in  input  32  operand.
- REQ-008: busy  output  1  high whenever state is not IDLE.
- REQ-009: done  output  1  one-cycle completion pulse.
- REQ-010: data_out  output  32  registered result; holds until the next completion.
- REQ-011: ext_shamt  output  32  latched shamt, zero-extended ({27'b0, shamt}), captured on accept.

Function
- REQ-012: The block SHALL implement states IDLE, SHIFT and DONE.
- REQ-013: IDLE with start=1 at an edge SHALL cause the following actions:
  - latch data_in into the accumulator, shamt into the counter, and op;
  - update ext_shamt;
  - go to SHIFT if shamt!=0, else go to DONE.
- REQ-014: IDLE with start=0 SHALL keep the block in IDLE with no register change.
- REQ-015: Each edge in SHIFT SHALL shift the accumulator by one bit per the latched op and decrement the counter; when the counter is 1 before the edge, the next state SHALL be DONE.
- REQ-016: Shift rules SHALL be as follows:
  - SLL fills 0 at bit 0;
  - SRL fills 0 at bit 31;
  - SRA replicates bit 31;
  - ROTR moves bit 0 into bit 31.
- REQ-017: In DONE, done=1 and data_out SHALL equal the accumulator; the next edge SHALL return to IDLE unconditionally.
- REQ-018: Latency: done SHALL be visible exactly shamt+1 cycles after the cycle in which start was accepted (shamt=0 gives done in the next cycle).
- REQ-019: start while busy (SHIFT or DONE) SHALL be ignored and not queued; op, shamt and data_in changes while busy SHALL have no effect.
- REQ-020: done SHALL never be high for two consecutive cycles; back-to-back operations SHALL have a minimum spacing of one IDLE cycle.
- REQ-021: data_out SHALL be updated only on entry to DONE.

Reset
- REQ-022: Asserting rst SHALL immediately, at any point including mid-shift, force the following:
  - state=IDLE;
  - busy=0 and done=0;
  - accumulator, counter, data_out and ext_shamt all 0.
  Any in-flight operation SHALL be discarded.
- REQ-023: After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
- REQ-024: With macro SHIFT_SEQ_SINGLE_CYCLE_EN defined, the SHIFT state SHALL perform the full shamt-bit shift in one edge.
  - Latency SHALL then be 2 cycles for shamt!=0 and 1 cycle for shamt=0.
  - Results and handshakes SHALL be identical to REQ-013..REQ-021.
- REQ-025: Without SHIFT_SEQ_SINGLE_CYCLE_EN, the block SHALL use the one-bit-per-cycle iteration of REQ-015 and contain no barrel shifter.

Verification
- REQ-026: SLL, data_in=0x00000001, shamt=31 -> done 32 cycles after accept cycle; data_out=0x80000000; ext_shamt=0x0000001F.
- REQ-027: SRA, data_in=0x80000000, shamt=4 -> data_out=0xF8000000, done 5 cycles after accept; SRL with the same inputs -> 0x08000000.
- REQ-028: SRL, data_in=0xDEADBEEF, shamt=0 -> done in the next cycle, data_out=0xDEADBEEF, busy high for exactly 1 cycle.
- REQ-029: ROTR, data_in=0x00000001, shamt=1 -> data_out=0x80000000; a second start pulsed while busy is ignored (exactly one done pulse).
- REQ-030: Start SLL shamt=10, assert rst after 3 shift cycles -> busy, done, data_out and ext_shamt read 0 within the same cycle; a new SLL 0x3 shamt=2 then yields 0x0000000C.
- REQ-031: SHIFT_SEQ_SINGLE_CYCLE_EN defined: SLL 0x00000001 shamt=31 -> done 2 cycles after accept, data_out=0x80000000.
